reg_access_ctrl: RTL
====================

REG_ACCESS_CTRL -- requirements
Module: reg_access_ctrl

Interface
REQ-001 The block SHALL have parameter reg_count, default 11, giving the number of registers in the attached register file.
REQ-002 The block SHALL have parameter reg_width, default 12, giving the data width in bits.
REQ-003 The block SHALL have parameter addr_width, default 4, giving the register index width; it SHALL be at least ceil(log2(reg_count)).
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: the reset; it is synchronous and active-low (0 = reset).
REQ-006 The block SHALL have port req_valid, input, 1 bit: a request is present.
REQ-007 The block SHALL have port req_ready, output, 1 bit: the block accepts a request.
REQ-008 The block SHALL have port req_op, input, 2 bits: 00 NOP, 01 WRITE, 10 READ, 11 MOVE.
REQ-009 The block SHALL have port req_dst, input, addr_width bits: the write or move destination index.
REQ-010 The block SHALL have port req_src, input, addr_width bits: the read or move source index.
REQ-011 The block SHALL have port req_data, input, reg_width bits: the write data.
REQ-012 The block SHALL have port rsp_valid, output, 1 bit: a response is present.
REQ-013 The block SHALL have port rsp_ready, input, 1 bit: the response is consumed.
REQ-014 The block SHALL have port rsp_data, output, reg_width bits: the read, moved or written value.
REQ-015 The block SHALL have port rsp_err, output, 1 bit: an index was out of range.
REQ-016 The block SHALL have port read_en, output, reg_count bits: one-hot register read select.
REQ-017 The block SHALL have port write_en, output, reg_count bits: one-hot register write strobe.
REQ-018 The block SHALL have port datain, output, reg_width bits: data to the register file.
REQ-019 The block SHALL have port dataout, input, reg_width bits: the register file read data, valid one cycle after read_en is asserted.

Function
REQ-020 The block SHALL implement states IDLE, RD, CAP, WR and RSP.
REQ-021 req_ready SHALL be 1 only in IDLE; a request SHALL be accepted on a rising edge with req_valid=1 and req_ready=1, and the op, indices and data SHALL be latched on acceptance.
REQ-022 For NOP, IDLE SHALL go to RSP with rsp_err=0 and rsp_data=0.
REQ-023 For WRITE, the path SHALL be IDLE->WR->RSP: in WR, exactly write_en[dst]=1 for one cycle with datain=req_data; rsp_data SHALL be req_data.
REQ-024 For READ, the path SHALL be IDLE->RD->CAP->RSP: read_en[src]=1 in both RD and CAP, and dataout SHALL be captured at the end of CAP into rsp_data.
REQ-025 For MOVE, the path SHALL be IDLE->RD->CAP->WR->RSP: in WR, datain SHALL be the captured value with write_en[dst]=1; rsp_data SHALL be the moved value.
REQ-026 Latency from the acceptance edge to rsp_valid=1 SHALL be 1 cycle for NOP, 2 for WRITE, 3 for READ and 4 for MOVE.
REQ-027 Any used index >= reg_count SHALL go IDLE->RSP directly with rsp_err=1 and rsp_data=0, and no enable SHALL be asserted.
REQ-028 RSP SHALL hold rsp_valid, rsp_data and rsp_err stable until rsp_ready=1, then return to IDLE; no new request SHALL be accepted in the same cycle.
REQ-029 read_en and write_en SHALL each have at most one bit set, SHALL never be nonzero in the same cycle, and SHALL be 0 in IDLE and RSP.
REQ-030 datain SHALL be 0 whenever write_en is 0.
REQ-031 MOVE with src equal to dst SHALL execute normally, rewriting the same value.

Reset
REQ-032 With reset=0 at a rising edge, the block SHALL enter IDLE and drive rsp_valid=0, rsp_err=0, rsp_data=0, read_en=0, write_en=0 and datain=0 from the next cycle.
REQ-033 req_ready SHALL be 0 while reset=0.
REQ-034 A reset during RD, CAP or WR SHALL discard the operation, and no write_en pulse SHALL follow it.

Structure
REQ-035 A shared package SHALL hold the op encodings (OP_NOP, OP_WRITE, OP_READ, OP_MOVE) and the state enumeration.
REQ-036 A sub-module reg_onehot_dec SHALL convert index plus enable to a reg_count-bit one-hot vector and SHALL be instantiated twice (read and write).

Verification
REQ-037 WRITE dst=0, data=12'h704 -> write_en=11'b00000000001 for 1 cycle, datain=12'h704, rsp_valid 2 cycles after accept, rsp_data=12'h704.
REQ-038 READ src=0 after REQ-037 with a register-file model -> read_en=...001 for 2 cycles, rsp_data=12'h704 at +3, rsp_err=0.
REQ-039 MOVE src=0, dst=10 -> read_en bit0 for 2 cycles, then write_en=11'b10000000000 with datain=12'h704, rsp at +4; a later READ src=10 returns 12'h704.
REQ-040 WRITE dst=11 (out of range) -> no enables, rsp_err=1, rsp at +1.
REQ-041 Hold rsp_ready=0 for 5 cycles -> rsp_valid and rsp_data stable, req_ready=0 throughout; release -> IDLE next cycle.
REQ-042 reset=0 asserted in CAP of a MOVE -> all outputs 0 next cycle, no write_en pulse ever, the destination is unchanged.

Source files
------------

// File: rtl/reg_access_ctrl_pkg.sv
// Shared definitions for the register access controller: request opcodes
// and the controller state encoding.
package reg_access_ctrl_pkg;

    typedef enum logic [1:0] {
        OP_NOP   = 2'b00,
        OP_WRITE = 2'b01,
        OP_READ  = 2'b10,
        OP_MOVE  = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        CAP,
        WR,
        RSP
    } state_e;

endpackage

// File: rtl/reg_onehot_dec.sv
// Index-to-one-hot decoder. An index at or beyond reg_count yields an
// all-zero vector, so a bad index can never produce a stray strobe.
module reg_onehot_dec #(
    parameter int reg_count  = 11,
    parameter int addr_width = 4
) (
    input  logic [addr_width-1:0] idx,
    input  logic                  en,
    output logic [reg_count-1:0]  onehot
);

    always_comb begin
        onehot = '0;
        for (int i = 0; i < reg_count; i++) begin
            onehot[i] = en && (int'(idx) == i);
        end
    end

endmodule

// File: rtl/reg_access_ctrl.sv
// Register access controller: accepts NOP/WRITE/READ/MOVE requests and
// sequences the one-hot read/write strobes of an attached register file.
module reg_access_ctrl
    import reg_access_ctrl_pkg::*;
#(
    parameter int reg_count  = 11,
    parameter int reg_width  = 12,
    parameter int addr_width = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [1:0]            req_op,
    input  logic [addr_width-1:0] req_dst,
    input  logic [addr_width-1:0] req_src,
    input  logic [reg_width-1:0]  req_data,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [reg_width-1:0]  rsp_data,
    output logic                  rsp_err,
    output logic [reg_count-1:0]  read_en,
    output logic [reg_count-1:0]  write_en,
    output logic [reg_width-1:0]  datain,
    input  logic [reg_width-1:0]  dataout
);

    state_e                state_q, state_d;
    op_e                   op_q, op_d;
    logic [addr_width-1:0] dst_q, dst_d;
    logic [addr_width-1:0] src_q, src_d;
    logic [reg_width-1:0]  data_q, data_d;
    logic                  err_q, err_d;

    logic                  dst_bad;
    logic                  src_bad;
    logic                  rd_active;
    logic                  wr_active;

    assign dst_bad = int'(req_dst) >= reg_count;
    assign src_bad = int'(req_src) >= reg_count;

    // data_q carries the write data, then the captured read value, and is
    // what the response presents; it is zeroed for NOP and error responses.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        dst_d   = dst_q;
        src_d   = src_q;
        data_d  = data_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (req_valid && req_ready) begin
                    op_d   = op_e'(req_op);
                    dst_d  = req_dst;
                    src_d  = req_src;
                    data_d = req_data;
                    err_d  = 1'b0;
                    case (op_e'(req_op))
                        OP_NOP: begin
                            data_d  = '0;
                            state_d = RSP;
                        end
                        OP_WRITE: begin
                            if (dst_bad) begin
                                err_d   = 1'b1;
                                data_d  = '0;
                                state_d = RSP;
                            end else begin
                                state_d = WR;
                            end
                        end
                        OP_READ: begin
                            if (src_bad) begin
                                err_d   = 1'b1;
                                data_d  = '0;
                                state_d = RSP;
                            end else begin
                                state_d = RD;
                            end
                        end
                        default: begin
                            if (src_bad || dst_bad) begin
                                err_d   = 1'b1;
                                data_d  = '0;
                                state_d = RSP;
                            end else begin
                                state_d = RD;
                            end
                        end
                    endcase
                end
            end
            RD:  state_d = CAP;
            CAP: begin
                data_d  = dataout;
                state_d = (op_q == OP_MOVE) ? WR : RSP;
            end
            WR:  state_d = RSP;
            RSP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            op_q    <= OP_NOP;
            dst_q   <= '0;
            src_q   <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            dst_q   <= dst_d;
            src_q   <= src_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

    assign req_ready = reset && (state_q == IDLE);
    assign rsp_valid = (state_q == RSP);
    assign rsp_data  = rsp_valid ? data_q : '0;
    assign rsp_err   = rsp_valid && err_q;

    // Read select is held across RD and CAP so the one-cycle read data is
    // still addressed when it is captured.
    assign rd_active = (state_q == RD) || (state_q == CAP);
    assign wr_active = (state_q == WR);
    assign datain    = wr_active ? data_q : '0;

    reg_onehot_dec #(
        .reg_count  (reg_count),
        .addr_width (addr_width)
    ) u_read_dec (
        .idx    (src_q),
        .en     (rd_active),
        .onehot (read_en)
    );

    reg_onehot_dec #(
        .reg_count  (reg_count),
        .addr_width (addr_width)
    ) u_write_dec (
        .idx    (dst_q),
        .en     (wr_active),
        .onehot (write_en)
    );

endmodule
